isq_alloc: RTL and testbench
============================

Name: isq_alloc

Overview:
- Dispatch-side allocator directly upstream of the issue-queue line array.
- Accepts one renamed instruction per cycle over a valid/ready handshake and buffers it in a one-entry pipeline register.
- Picks the lowest-index free issue-queue line and drives that line's write enable and write data: {brn_wat, wat, inst}.
- Owns the per-line valid vector, because the lines themselves hold no valid bit. It frees lines on issue and clears everything on flush.

Parameters:
- INST_WIDTH, 56, width of the instruction payload field of a line.
- ISQ_DEPTH, 16, number of issue-queue lines.
- ISQ_IDX_WIDTH, 4, log2(ISQ_DEPTH).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- dsp_vld  input  1  dispatch offers an instruction.
- dsp_rdy  output  1  allocator can accept this cycle.
- dsp_inst  input  INST_WIDTH  instruction payload.
- dsp_wat  input  1  operands not ready; becomes the line wait bit.
- dsp_brn  input  1  unresolved branch; becomes the line brn_wat bit.
- iss_fre  input  ISQ_DEPTH  one-hot (or zero) set of lines issued this cycle; those lines are freed.
- flush  input  1  mispredict/exception flush.
- isq_wr_en  output  ISQ_DEPTH  one-hot line write enable; connects to each line's en.
- isq_wr_data  output  INST_WIDTH+2  {brn_wat, wat, inst}; shared by all lines.
- isq_fls_inst  output  1  registered flush pulse to every line's fls_inst.
- isq_val  output  ISQ_DEPTH  per-line valid vector.
- isq_cnt  output  ISQ_IDX_WIDTH+1  number of valid lines.
- isq_full  output  1  isq_cnt == ISQ_DEPTH.
- isq_empty  output  1  isq_cnt == 0.
- iss_err  output  1  sticky flag: issue seen on a line whose valid bit was clear.

Behaviour:
- Reset (async, rst_n low): all state is cleared.
  - Pipeline valid p_vld = 0; payload register = 0.
  - isq_val = 0, isq_cnt = 0, isq_empty = 1, isq_full = 0.
  - isq_wr_en = 0, isq_fls_inst = 0, iss_err = 0.
  - Reset mid-transfer discards the buffered instruction.
- Accept: dsp_rdy = ~flush & (~p_vld | wr_fire).
  - When dsp_vld & dsp_rdy is high at an edge, {dsp_brn, dsp_wat, dsp_inst} loads into the payload register and p_vld is set.
  - Otherwise p_vld clears when wr_fire occurs.
- Write stage (combinational from registers):
  - free = ~isq_val; sel = lowest-index set bit of free.
  - wr_fire = p_vld & |free & ~flush.
  - isq_wr_en = wr_fire ? onehot(sel) : 0.
  - isq_wr_data = payload register at all times.
- Latency: at least one cycle from dispatch handshake to line write. Back-to-back dispatch sustains one instruction per cycle while lines are free.
- Valid update each edge: isq_val_next = (isq_val & ~iss_fre) | isq_wr_en.
  - A line freed by iss_fre becomes available for selection the following cycle, not the same cycle.
  - A line cannot be written and freed in the same cycle, because the write targets an invalid line.
- Count update: isq_cnt_next = isq_cnt + wr_fire - popcount(iss_fre & isq_val).
  - It never wraps; a bench assertion requires 0 <= isq_cnt <= ISQ_DEPTH.
- Full: p_vld stays set and the payload is held stable; dsp_rdy is low until a line frees.
- Issue on an invalid line: ignored for valid/count purposes; iss_err is set and stays set until reset.
- Flush: at the edge where flush is high:
  - isq_val, isq_cnt and p_vld clear.
  - isq_fls_inst pulses high for exactly the next cycle.
  - No isq_wr_en in the flush cycle; any concurrent iss_fre is ignored.
  - In the cycle after flush, accepts resume (dsp_rdy = 1).
- Simultaneous write + issue of different lines: count is unchanged, and both valid updates apply.

Optional Feature:
- Macro: ISQ_ALLOC_PERF_EN.
- When defined: adds output stl_cnt [15:0], a saturating counter (sticks at 16'hFFFF).
  - Increments on every cycle with p_vld & ~|free & ~flush.
  - Cleared only by reset.
- When undefined: the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then dispatch 3 back-to-back instructions (inst=1,2,3; wat=1; brn=0) -> isq_wr_en = 0x0001, 0x0002, 0x0004 on cycles 2-4; isq_wr_data = {0,1,inst}; isq_cnt = 3.
- Fill all 16 lines, then hold dsp_vld with inst=0xAA -> isq_full=1 and dsp_rdy=0, payload held; issue line 5 (iss_fre=0x0020) -> next cycle isq_wr_en=0x0020 with 0xAA and cnt returns to 16.
- With lines 0-3 valid, issue line 1 and write into line 4 in the same cycle -> isq_val=0x001D, cnt unchanged at 4.
- With 6 valid lines and p_vld=1, assert flush -> next cycle isq_val=0, cnt=0, isq_fls_inst=1 for exactly one cycle, no isq_wr_en, dsp_rdy=1.
- Assert iss_fre=0x8000 with line 15 invalid -> isq_val and cnt unchanged, iss_err=1 and stays set.
- With ISQ_ALLOC_PERF_EN defined, hold full with p_vld=1 for 10 cycles -> stl_cnt=10; assert rst_n low mid-stall -> stl_cnt=0 and all outputs at reset values.

Source files
------------

// File: rtl/isq_alloc.sv
// isq_alloc: dispatch-side allocator for the issue-queue line array.
// Buffers one dispatched instruction, writes it into the lowest free line,
// and tracks per-line valid bits, occupancy count, flush and issue errors.
// Optional feature macro: ISQ_ALLOC_PERF_EN adds the stl_cnt stall counter.
module isq_alloc #(
  parameter int INST_WIDTH    = 56,
  parameter int ISQ_DEPTH     = 16,
  parameter int ISQ_IDX_WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       dsp_vld,
  output logic                       dsp_rdy,
  input  logic [INST_WIDTH-1:0]      dsp_inst,
  input  logic                       dsp_wat,
  input  logic                       dsp_brn,
  input  logic [ISQ_DEPTH-1:0]       iss_fre,
  input  logic                       flush,
  output logic [ISQ_DEPTH-1:0]       isq_wr_en,
  output logic [INST_WIDTH+1:0]      isq_wr_data,
  output logic                       isq_fls_inst,
  output logic [ISQ_DEPTH-1:0]       isq_val,
  output logic [ISQ_IDX_WIDTH:0]     isq_cnt,
  output logic                       isq_full,
  output logic                       isq_empty,
  output logic                       iss_err
`ifdef ISQ_ALLOC_PERF_EN
  ,
  output logic [15:0]                stl_cnt
`endif
);

  logic                   p_vld_q,   p_vld_d;
  logic [INST_WIDTH+1:0]  payload_q, payload_d;
  logic [ISQ_DEPTH-1:0]   val_q,     val_d;
  logic [ISQ_IDX_WIDTH:0] cnt_q,     cnt_d;
  logic                   fls_q,     fls_d;
  logic                   err_q,     err_d;

  logic [ISQ_DEPTH-1:0]   free;
  logic [ISQ_DEPTH-1:0]   sel_oh;
  logic [ISQ_DEPTH-1:0]   rel;
  logic [ISQ_IDX_WIDTH:0] rel_cnt;
  logic                   wr_fire;
  logic                   accept;

  // Write stage: lowest free line selection and handshake qualification
  always_comb begin
    free    = ~val_q;
    // x & -x isolates the lowest set bit
    sel_oh  = free & (~free + {{(ISQ_DEPTH-1){1'b0}}, 1'b1});
    wr_fire = p_vld_q & (|free) & ~flush;
    dsp_rdy = ~flush & (~p_vld_q | wr_fire);
    accept  = dsp_vld & dsp_rdy;
    isq_wr_en   = wr_fire ? sel_oh : '0;
    isq_wr_data = payload_q;
  end

  // Count of valid lines released by this cycle's issue vector
  always_comb begin
    rel     = iss_fre & val_q;
    rel_cnt = '0;
    for (int unsigned i = 0; i < ISQ_DEPTH; i++) begin
      rel_cnt = rel_cnt + (ISQ_IDX_WIDTH+1)'(rel[i]);
    end
  end

  // Next-state for pipeline register, valid vector, count, flush and error
  always_comb begin
    p_vld_d   = p_vld_q;
    payload_d = payload_q;
    val_d     = val_q;
    cnt_d     = cnt_q;
    fls_d     = flush;
    err_d     = err_q;
    if (flush) begin
      p_vld_d = 1'b0;
      val_d   = '0;
      cnt_d   = '0;
    end else begin
      if (accept) begin
        p_vld_d   = 1'b1;
        payload_d = {dsp_brn, dsp_wat, dsp_inst};
      end else if (wr_fire) begin
        p_vld_d = 1'b0;
      end
      val_d = (val_q & ~iss_fre) | isq_wr_en;
      cnt_d = cnt_q + (ISQ_IDX_WIDTH+1)'(wr_fire) - rel_cnt;
      if (|(iss_fre & ~val_q)) err_d = 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_vld_q   <= 1'b0;
      payload_q <= '0;
      val_q     <= '0;
      cnt_q     <= '0;
      fls_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      p_vld_q   <= p_vld_d;
      payload_q <= payload_d;
      val_q     <= val_d;
      cnt_q     <= cnt_d;
      fls_q     <= fls_d;
      err_q     <= err_d;
    end
  end

  assign isq_val      = val_q;
  assign isq_cnt      = cnt_q;
  assign isq_fls_inst = fls_q;
  assign iss_err      = err_q;
  assign isq_full     = (cnt_q == (ISQ_IDX_WIDTH+1)'(ISQ_DEPTH));
  assign isq_empty    = (cnt_q == '0);

`ifdef ISQ_ALLOC_PERF_EN
  logic [15:0] stl_q, stl_d;

  // Saturating count of cycles a buffered instruction waits on a full queue
  always_comb begin
    stl_d = stl_q;
    if (p_vld_q & ~(|free) & ~flush & (stl_q != '1)) stl_d = stl_q + 16'd1;
  end

  // Stall counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stl_q <= '0;
    else        stl_q <= stl_d;
  end

  assign stl_cnt = stl_q;
`endif

endmodule

// File: tb/tb_isq_alloc.sv
// Directed self-checking bench for isq_alloc.
module tb_isq_alloc;

  logic        clk;
  logic        rst_n;
  logic        dsp_vld;
  logic        dsp_rdy;
  logic [55:0] dsp_inst;
  logic        dsp_wat;
  logic        dsp_brn;
  logic [15:0] iss_fre;
  logic        flush;
  logic [15:0] isq_wr_en;
  logic [57:0] isq_wr_data;
  logic        isq_fls_inst;
  logic [15:0] isq_val;
  logic [4:0]  isq_cnt;
  logic        isq_full;
  logic        isq_empty;
  logic        iss_err;
`ifdef ISQ_ALLOC_PERF_EN
  logic [15:0] stl_cnt;
`endif

  int total = 0;
  int bad   = 0;

  isq_alloc #(.INST_WIDTH(56), .ISQ_DEPTH(16), .ISQ_IDX_WIDTH(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .dsp_vld      (dsp_vld),
    .dsp_rdy      (dsp_rdy),
    .dsp_inst     (dsp_inst),
    .dsp_wat      (dsp_wat),
    .dsp_brn      (dsp_brn),
    .iss_fre      (iss_fre),
    .flush        (flush),
    .isq_wr_en    (isq_wr_en),
    .isq_wr_data  (isq_wr_data),
    .isq_fls_inst (isq_fls_inst),
    .isq_val      (isq_val),
    .isq_cnt      (isq_cnt),
    .isq_full     (isq_full),
    .isq_empty    (isq_empty),
    .iss_err      (iss_err)
`ifdef ISQ_ALLOC_PERF_EN
    ,
    .stl_cnt      (stl_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] wd(input logic brn, input logic wat, input logic [55:0] inst);
    return {6'b0, brn, wat, inst};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_val"},   64'(isq_val), 64'h0);
    chk({tag, "_cnt"},   64'(isq_cnt), 64'd0);
    chk({tag, "_empty"}, 64'(isq_empty), 64'd1);
    chk({tag, "_full"},  64'(isq_full), 64'd0);
    chk({tag, "_wren"},  64'(isq_wr_en), 64'h0);
    chk({tag, "_fls"},   64'(isq_fls_inst), 64'd0);
    chk({tag, "_err"},   64'(iss_err), 64'd0);
    chk({tag, "_rdy"},   64'(dsp_rdy), 64'd1);
  endtask

  // Occupancy must stay within 0..16 at every sampled cycle
  always @(negedge clk) begin
    if (rst_n) chk("cnt_range", 64'(isq_cnt <= 5'd16), 64'd1);
  end

  initial begin
    rst_n = 1'b0; dsp_vld = 1'b0; dsp_inst = '0; dsp_wat = 1'b0; dsp_brn = 1'b0;
    iss_fre = '0; flush = 1'b0;
    #2;
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Three back-to-back dispatches: lines 0,1,2 written one cycle after handshake
    dsp_vld = 1'b1; dsp_wat = 1'b1; dsp_brn = 1'b0; dsp_inst = 56'd1;
    #1 chk("b2b_rdy0", 64'(dsp_rdy), 64'd1);
    chk("b2b_wren0", 64'(isq_wr_en), 64'h0);
    tick();
    dsp_inst = 56'd2;
    #1 chk("b2b_wren1", 64'(isq_wr_en), 64'h0001);
    chk("b2b_data1", 64'(isq_wr_data), wd(1'b0, 1'b1, 56'd1));
    tick();
    dsp_inst = 56'd3;
    #1 chk("b2b_wren2", 64'(isq_wr_en), 64'h0002);
    chk("b2b_data2", 64'(isq_wr_data), wd(1'b0, 1'b1, 56'd2));
    tick();
    dsp_vld = 1'b0;
    #1 chk("b2b_wren3", 64'(isq_wr_en), 64'h0004);
    chk("b2b_data3", 64'(isq_wr_data), wd(1'b0, 1'b1, 56'd3));
    tick();
    chk("b2b_cnt", 64'(isq_cnt), 64'd3);
    chk("b2b_val", 64'(isq_val), 64'h0007);
    chk("b2b_wren_idle", 64'(isq_wr_en), 64'h0);

    // Fill all 16 lines, then leave 0xAA buffered against a full queue
    for (int i = 0; i < 13; i++) begin
      dsp_vld = 1'b1; dsp_inst = 56'(4 + i);
      tick();
    end
    chk("fill_cnt15", 64'(isq_cnt), 64'd15);
    dsp_inst = 56'hAA;
    tick();
    dsp_inst = 56'hBB;
    #1 chk("full_flag", 64'(isq_full), 64'd1);
    chk("full_cnt", 64'(isq_cnt), 64'd16);
    chk("full_rdy", 64'(dsp_rdy), 64'd0);
    chk("full_wren", 64'(isq_wr_en), 64'h0);
    chk("full_data", 64'(isq_wr_data), wd(1'b0, 1'b1, 56'hAA));
    tick();
    chk("stall_data", 64'(isq_wr_data), wd(1'b0, 1'b1, 56'hAA));
    chk("stall_rdy", 64'(dsp_rdy), 64'd0);
    dsp_vld = 1'b0;
    iss_fre = 16'h0020;
    #1 chk("free_same_cyc_wren", 64'(isq_wr_en), 64'h0);
    tick();
    iss_fre = '0;
    #1 chk("refill_wren", 64'(isq_wr_en), 64'h0020);
    chk("refill_data", 64'(isq_wr_data), wd(1'b0, 1'b1, 56'hAA));
    chk("refill_cnt15", 64'(isq_cnt), 64'd15);
    chk("refill_rdy", 64'(dsp_rdy), 64'd1);
    tick();
    chk("refill_cnt16", 64'(isq_cnt), 64'd16);
    chk("refill_val", 64'(isq_val), 64'hFFFF);

    // Free every line at once
    iss_fre = 16'hFFFF;
    tick();
    iss_fre = '0;
    chk("freeall_cnt", 64'(isq_cnt), 64'd0);
    chk("freeall_empty", 64'(isq_empty), 64'd1);
    chk("freeall_err", 64'(iss_err), 64'd0);

    // Lines 0-3 valid, then issue line 1 while writing line 4
    dsp_vld = 1'b1; dsp_inst = 56'h10; tick();
    dsp_inst = 56'h11; tick();
    dsp_inst = 56'h12; tick();
    dsp_inst = 56'h13; tick();
    dsp_vld = 1'b0; tick();
    chk("l03_val", 64'(isq_val), 64'h000F);
    dsp_vld = 1'b1; dsp_inst = 56'h14; tick();
    dsp_vld = 1'b0; iss_fre = 16'h0002;
    #1 chk("wi_wren", 64'(isq_wr_en), 64'h0010);
    tick();
    iss_fre = '0;
    chk("wi_val", 64'(isq_val), 64'h001D);
    chk("wi_cnt", 64'(isq_cnt), 64'd4);

    // Six valid lines with one buffered, then flush with a concurrent issue
    dsp_vld = 1'b1; dsp_inst = 56'h15; tick();
    dsp_inst = 56'h16; tick();
    dsp_inst = 56'h17; tick();
    dsp_vld = 1'b0;
    chk("pre_fl_val", 64'(isq_val), 64'h003F);
    chk("pre_fl_cnt", 64'(isq_cnt), 64'd6);
    flush = 1'b1; iss_fre = 16'h0001;
    #1 chk("fl_wren", 64'(isq_wr_en), 64'h0);
    chk("fl_rdy", 64'(dsp_rdy), 64'd0);
    tick();
    flush = 1'b0; iss_fre = '0;
    #1 chk("postfl_val", 64'(isq_val), 64'h0);
    chk("postfl_cnt", 64'(isq_cnt), 64'd0);
    chk("postfl_fls", 64'(isq_fls_inst), 64'd1);
    chk("postfl_wren", 64'(isq_wr_en), 64'h0);
    chk("postfl_rdy", 64'(dsp_rdy), 64'd1);
    chk("postfl_err", 64'(iss_err), 64'd0);
    tick();
    chk("postfl_fls_off", 64'(isq_fls_inst), 64'd0);
    chk("postfl_wren2", 64'(isq_wr_en), 64'h0);

    // Issue on an invalid line
    dsp_vld = 1'b1; dsp_inst = 56'h20; tick();
    dsp_vld = 1'b0; tick();
    chk("pre_err_val", 64'(isq_val), 64'h0001);
    iss_fre = 16'h8000;
    tick();
    iss_fre = '0;
    chk("err_val", 64'(isq_val), 64'h0001);
    chk("err_cnt", 64'(isq_cnt), 64'd1);
    chk("err_set", 64'(iss_err), 64'd1);
    tick(); tick();
    chk("err_sticky", 64'(iss_err), 64'd1);

    // Reset clears everything, including the sticky error
    rst_n = 1'b0;
    #1 chk_reset_vals("reset2");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Fill and stall for ten cycles, then reset mid-stall
    dsp_vld = 1'b1;
    for (int i = 0; i < 17; i++) begin
      dsp_inst = 56'(16'h100 + i);
      tick();
    end
    dsp_vld = 1'b0;
    chk("stall_full", 64'(isq_full), 64'd1);
    chk("stall_rdy2", 64'(dsp_rdy), 64'd0);
    chk("stall_payload", 64'(isq_wr_data), wd(1'b0, 1'b1, 56'h110));
`ifdef ISQ_ALLOC_PERF_EN
    chk("stl_start", 64'(stl_cnt), 64'd0);
`endif
    for (int i = 0; i < 10; i++) tick();
`ifdef ISQ_ALLOC_PERF_EN
    chk("stl_10", 64'(stl_cnt), 64'd10);
`endif
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("reset3");
`ifdef ISQ_ALLOC_PERF_EN
    chk("stl_reset", 64'(stl_cnt), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("reset3_discard_wren", 64'(isq_wr_en), 64'h0);
    chk("reset3_discard_cnt", 64'(isq_cnt), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
